alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- In-order issue buffer on the initiator side of the ALU operand interface (SrcA/SrcB/ALUControl) in the superscalar core.
- Accepts one decoded ALU op per cycle from decode/regread and stores it in a circular queue.
- Issues up to two oldest ops per cycle to ALU lane 0 and lane 1, holding lane 1 back on an intra-pair RAW hazard.
- Provides flush for branch mispredict.

Parameters:
- DEPTH, 8, queue entries; power of 2, >= 2.
- RW, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous queue clear; takes priority over enqueue and issue.
- in_valid  in  1  enqueue request.
- in_ready  out  1  queue can accept; high iff count < DEPTH. Does not depend on same-cycle issue.
- in_SrcA  in  32  operand A value.
- in_SrcB  in  32  operand B value.
- in_ALUControl  in  4  ALU op code (0000..1001, 1111 legal).
- in_rd  in  RW  destination register.
- in_rs1  in  RW  source register index for A; 0 = no dependency.
- in_rs2  in  RW  source register index for B; 0 = no dependency.
- stall  in  1  lanes cannot accept; no issue this cycle.
- lane0_valid  out  1  lane 0 carries an op.
- lane0_SrcA, lane0_SrcB  out  32 each  lane 0 operands.
- lane0_ALUControl  out  4  lane 0 op code.
- lane0_rd  out  RW  lane 0 destination.
- lane1_valid, lane1_SrcA, lane1_SrcB, lane1_ALUControl, lane1_rd  out  1/32/32/4/RW  same fields for lane 1.
- count  out  $clog2(DEPTH)+1  current occupancy.
- illegal_op  out  1  see Optional Feature; tied 0 when the feature is disabled.

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and count register. Pointers wrap modulo DEPTH.
- Reset (rst=1 at posedge): head=tail=count=0; all lane*_valid=0; all lane data outputs 0; illegal_op=0.
- Accept: in_valid && in_ready writes the entry at tail; tail advances by 1.
- Latency: an op accepted at edge N drives lane0 from edge N onward, i.e. visible in cycle N+1. There is no same-cycle bypass.
- Lane outputs are combinational from registered queue state:
  - lane0 = entry[head], valid iff count >= 1 && !stall.
  - lane1 = entry[head+1], valid iff count >= 2 && !stall && !hazard.
- Hazard: entry[head].rd != 0 && (entry[head+1].rs1 == entry[head].rd || entry[head+1].rs2 == entry[head].rd).
- Invalid lanes drive zeros on all data fields.
- Issue: at the edge, head advances by the number of valid lanes (0, 1 or 2).
  - count_next = count + accepted - issued.
  - Simultaneous accept and issue at full or empty is legal and handled by this arithmetic.
- Full: in_ready=0 even if an issue occurs that cycle. No overflow is possible; in_valid while full is ignored.
- Empty: both lanes invalid; accepts still proceed.
- Wrap: head+1 indexes modulo DEPTH, so lane1 may read entry 0 when head=DEPTH-1.
- flush: head=tail=count=0 and lanes forced invalid in that cycle; the same-cycle in_valid is dropped.
- rst asserted mid-operation behaves as flush and also clears illegal_op.
- Ordering: lane1 never issues without lane0. Issue order equals enqueue order.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- Enabled:
  - An accepted op with ALUControl in 1010..1110 is not written; tail and count are unchanged.
  - illegal_op pulses high for exactly the cycle after the accept.
- Disabled: all codes are queued and issued unchanged; illegal_op is tied 0.

Test Plan:
- Reset, then enqueue ADD (A=5, B=3, rd=1). Next cycle: lane0_valid=1, SrcA=5, SrcB=3, ALUControl=0000; lane1_valid=0. Following cycle: count=0.
- Enqueue two independent ops (rd=1, then rd=2 with rs1=3, rs2=4), stall=0. Both lanes valid in the same cycle; count goes 2->0.
- Enqueue rd=5 then rs1=5. Lane1 is held. Lane0 issues first, then the dependent op issues on lane0 the next cycle. A pair with rd=0 and rs1=0 dual-issues.
- Stall=1 while filling 8 entries. in_ready drops at count=8 and a 9th in_valid is ignored. Release stall: count drains 8->6->4->2->0. Drive 12 total ops so pointers wrap; all issue in order with correct values.
- With count=3, assert flush while in_valid=1. Next cycle: count=0, lanes invalid, in_ready=1. Assert rst mid-stream: same result, all outputs zero.
- With ALU_ISSUE_ILLEGAL_TRAP_EN defined, enqueue ALUControl=1100: illegal_op=1 for one cycle and count stays 0. Without the macro, the op issues on lane0 with ALUControl=1100.

Source files
------------

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//   In-order issue buffer that feeds the two ALU lanes of the superscalar core.
//   Decoded ALU ops arrive one per cycle and land in a circular queue. Each
//   cycle the two oldest entries are offered to lane 0 / lane 1. Lane 1 is
//   held back when it reads the register that lane 0 writes.
//
//   Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN
//     defined   : accepted ops with ALUControl 1010..1110 are dropped and
//                 illegal_op pulses for one cycle after the accept.
//     undefined : every code is queued as-is; illegal_op is tied low.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              queue clear (mispredict), wins over enqueue and issue
//   in_valid/in_ready  enqueue handshake; in_ready = (count < DEPTH)
//   in_SrcA/B, in_ALUControl, in_rd, in_rs1, in_rs2   op payload
//   stall              lanes cannot accept this cycle
//   lane0_* / lane1_*  issued ops, data fields zero when the lane is invalid
//   count              current occupancy
//   illegal_op         illegal-code trap pulse (feature build only)
// ---------------------------------------------------------------------------
module alu_issue_queue #(
   parameter int DEPTH = 8,
   parameter int RW    = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_SrcA,
   input  logic [31:0]                in_SrcB,
   input  logic [3:0]                 in_ALUControl,
   input  logic [RW-1:0]              in_rd,
   input  logic [RW-1:0]              in_rs1,
   input  logic [RW-1:0]              in_rs2,
   input  logic                       stall,
   output logic                       lane0_valid,
   output logic [31:0]                lane0_SrcA,
   output logic [31:0]                lane0_SrcB,
   output logic [3:0]                 lane0_ALUControl,
   output logic [RW-1:0]              lane0_rd,
   output logic                       lane1_valid,
   output logic [31:0]                lane1_SrcA,
   output logic [31:0]                lane1_SrcB,
   output logic [3:0]                 lane1_ALUControl,
   output logic [RW-1:0]              lane1_rd,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       illegal_op
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]   src_a;
      logic [31:0]   src_b;
      logic [3:0]    ctl;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;

   entry_t        ent0;
   entry_t        ent1;
   entry_t        new_ent;
   logic          hazard;
   logic          blocked;
   logic          l0_v;
   logic          l1_v;
   logic          accept;
   logic          write_en;
   logic [CW-1:0] issued;
   logic [PW-1:0] head_d;
   logic [PW-1:0] tail_d;
   logic [CW-1:0] count_d;

   // head+1 wraps naturally in PW bits, so lane 1 reads entry 0 at head=DEPTH-1
   assign ent0 = mem_q[head_q];
   assign ent1 = mem_q[head_q + PW'(1)];

   // Lane 1 must not read a register lane 0 is writing this same cycle; rd=0
   // is the zero register and never creates a dependency.
   assign hazard = (ent0.rd != '0) &&
                   ((ent1.rs1 == ent0.rd) || (ent1.rs2 == ent0.rd));

   assign blocked = rst || flush || stall;
   assign l0_v    = (count_q >= CW'(1)) && !blocked;
   assign l1_v    = (count_q >= CW'(2)) && !blocked && !hazard;

   assign lane0_valid      = l0_v;
   assign lane0_SrcA       = l0_v ? ent0.src_a : '0;
   assign lane0_SrcB       = l0_v ? ent0.src_b : '0;
   assign lane0_ALUControl = l0_v ? ent0.ctl   : '0;
   assign lane0_rd         = l0_v ? ent0.rd    : '0;

   assign lane1_valid      = l1_v;
   assign lane1_SrcA       = l1_v ? ent1.src_a : '0;
   assign lane1_SrcB       = l1_v ? ent1.src_b : '0;
   assign lane1_ALUControl = l1_v ? ent1.ctl   : '0;
   assign lane1_rd         = l1_v ? ent1.rd    : '0;

   // Readiness looks only at registered occupancy, never at same-cycle issue.
   assign in_ready = (count_q < CW'(DEPTH));
   assign count    = count_q;
   assign accept   = in_valid && in_ready && !flush && !rst;

   assign new_ent = '{src_a: in_SrcA, src_b: in_SrcB, ctl: in_ALUControl,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2};

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic code_bad;
   logic illegal_q;

   assign code_bad   = (in_ALUControl >= 4'b1010) && (in_ALUControl <= 4'b1110);
   assign write_en   = accept && !code_bad;
   assign illegal_op = illegal_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && code_bad;
      end
   end
`else
   assign write_en   = accept;
   assign illegal_op = 1'b0;
`endif

   assign issued  = CW'(l0_v) + CW'(l1_v);
   assign head_d  = head_q + PW'(issued);
   assign tail_d  = write_en ? tail_q + PW'(1) : tail_q;
   assign count_d = count_q + CW'(write_en) - issued;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is not reset; stale entries are never visible because
   // lanes are masked by count.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem_q[tail_q] <= new_ent;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, stall;
   logic        in_ready;
   logic [31:0] in_SrcA, in_SrcB;
   logic [3:0]  in_ALUControl;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic        lane0_valid, lane1_valid;
   logic [31:0] lane0_SrcA, lane0_SrcB, lane1_SrcA, lane1_SrcB;
   logic [3:0]  lane0_ALUControl, lane1_ALUControl;
   logic [4:0]  lane0_rd, lane1_rd;
   logic [3:0]  count;
   logic        illegal_op;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(8), .RW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_SrcA(in_SrcA), .in_SrcB(in_SrcB), .in_ALUControl(in_ALUControl),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .stall(stall),
      .lane0_valid(lane0_valid), .lane0_SrcA(lane0_SrcA), .lane0_SrcB(lane0_SrcB),
      .lane0_ALUControl(lane0_ALUControl), .lane0_rd(lane0_rd),
      .lane1_valid(lane1_valid), .lane1_SrcA(lane1_SrcA), .lane1_SrcB(lane1_SrcB),
      .lane1_ALUControl(lane1_ALUControl), .lane1_rd(lane1_rd),
      .count(count), .illegal_op(illegal_op)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endfunction

   // ---------------- behavioural model: queue of pending ops ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } op_t;

   op_t  mq[$];
   logic ill_m = 1'b0;

   // How many of the oldest ops the lanes may take this cycle.
   function automatic int n_issue();
      if (rst || flush || stall || mq.size() == 0) return 0;
      if (mq.size() == 1) return 1;
      if (mq[0].rd != 0 && (mq[1].rs1 == mq[0].rd || mq[1].rs2 == mq[0].rd)) return 1;
      return 2;
   endfunction

   always @(posedge clk) begin
      int  n;
      bit  acc;
      bit  bad;
      if (rst || flush) begin
         mq.delete();
         ill_m <= 1'b0;
      end else begin
         n   = n_issue();
         acc = in_valid && (mq.size() < 8);
         bad = (in_ALUControl >= 4'd10) && (in_ALUControl <= 4'd14);
         for (int k = 0; k < n; k++) void'(mq.pop_front());
         if (acc && !(TRAP && bad))
            mq.push_back('{a: in_SrcA, b: in_SrcB, c: in_ALUControl,
                           rd: in_rd, rs1: in_rs1, rs2: in_rs2});
         ill_m <= acc && TRAP && bad;
      end
   end

   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = n_issue();
         chk("m_count", 32'(count), 32'(mq.size()));
         chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 8));
         chk("m_illegal", 32'(illegal_op), 32'(ill_m));
         chk("m_l0_valid", 32'(lane0_valid), 32'(n >= 1));
         chk("m_l0_a", lane0_SrcA, (n >= 1) ? mq[0].a : 32'd0);
         chk("m_l0_b", lane0_SrcB, (n >= 1) ? mq[0].b : 32'd0);
         chk("m_l0_c", 32'(lane0_ALUControl), (n >= 1) ? 32'(mq[0].c) : 32'd0);
         chk("m_l0_rd", 32'(lane0_rd), (n >= 1) ? 32'(mq[0].rd) : 32'd0);
         chk("m_l1_valid", 32'(lane1_valid), 32'(n == 2));
         chk("m_l1_a", lane1_SrcA, (n == 2) ? mq[1].a : 32'd0);
         chk("m_l1_b", lane1_SrcB, (n == 2) ? mq[1].b : 32'd0);
         chk("m_l1_c", 32'(lane1_ALUControl), (n == 2) ? 32'(mq[1].c) : 32'd0);
         chk("m_l1_rd", 32'(lane1_rd), (n == 2) ? 32'(mq[1].rd) : 32'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      in_valid = 1'b1; in_SrcA = a; in_SrcB = b; in_ALUControl = c;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_SrcA = '0; in_SrcB = '0; in_ALUControl = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0;
      idle();
      cyc(); cyc();
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_l0_valid", 32'(lane0_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_illegal", 32'(illegal_op), 32'd0);

      // single ADD
      cyc();
      set_op(32'd5, 32'd3, 4'b0000, 5'd1, 5'd0, 5'd0);
      cyc();
      idle();
      @(negedge clk);
      chk("add_l0_valid", 32'(lane0_valid), 32'd1);
      chk("add_l0_a", lane0_SrcA, 32'd5);
      chk("add_l0_b", lane0_SrcB, 32'd3);
      chk("add_l0_c", 32'(lane0_ALUControl), 32'd0);
      chk("add_l1_valid", 32'(lane1_valid), 32'd0);
      cyc();
      @(negedge clk);
      chk("add_count_after", 32'(count), 32'd0);

      // independent pair dual-issues
      stall = 1'b1;
      set_op(32'd11, 32'd12, 4'b0001, 5'd1, 5'd0, 5'd0); cyc();
      set_op(32'd21, 32'd22, 4'b0010, 5'd2, 5'd3, 5'd4); cyc();
      idle(); stall = 1'b0;
      @(negedge clk);
      chk("pair_count", 32'(count), 32'd2);
      chk("pair_l0_valid", 32'(lane0_valid), 32'd1);
      chk("pair_l1_valid", 32'(lane1_valid), 32'd1);
      chk("pair_l1_rd", 32'(lane1_rd), 32'd2);
      chk("pair_l1_a", lane1_SrcA, 32'd21);
      cyc();
      @(negedge clk);
      chk("pair_count_after", 32'(count), 32'd0);

      // RAW hazard holds lane 1
      stall = 1'b1;
      set_op(32'd31, 32'd32, 4'b0011, 5'd5, 5'd0, 5'd0); cyc();
      set_op(32'd41, 32'd42, 4'b0100, 5'd6, 5'd5, 5'd0); cyc();
      idle(); stall = 1'b0;
      @(negedge clk);
      chk("raw_l0_valid", 32'(lane0_valid), 32'd1);
      chk("raw_l1_held", 32'(lane1_valid), 32'd0);
      chk("raw_l0_rd", 32'(lane0_rd), 32'd5);
      cyc();
      @(negedge clk);
      chk("raw_count_mid", 32'(count), 32'd1);
      chk("raw_dep_l0_rd", 32'(lane0_rd), 32'd6);
      chk("raw_dep_l0_a", lane0_SrcA, 32'd41);
      cyc();

      // rd=0 never creates a dependency
      stall = 1'b1;
      set_op(32'd51, 32'd52, 4'b0101, 5'd0, 5'd0, 5'd0); cyc();
      set_op(32'd61, 32'd62, 4'b0110, 5'd7, 5'd0, 5'd0); cyc();
      idle(); stall = 1'b0;
      @(negedge clk);
      chk("rd0_l1_valid", 32'(lane1_valid), 32'd1);
      cyc();

      // fill to full under stall; head=tail=7 so lane 1 wraps to entry 0
      stall = 1'b1;
      for (int i = 0; i < 9; i++) begin
         set_op(32'(100 + i), 32'(200 + i), 4'(i % 10), 5'(i + 8), 5'd0, 5'd0);
         if (i == 8) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            chk("full_count", 32'(count), 32'd8);
         end
         cyc();
      end
      idle(); stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("drain_count", 32'(count), 32'(8 - 2 * k));
         if (k == 0) chk("wrap_l1_a", lane1_SrcA, 32'd101);
         cyc();
      end
      @(negedge clk);
      chk("drain_empty", 32'(count), 32'd0);
      for (int i = 9; i < 13; i++) begin
         set_op(32'(100 + i), 32'(200 + i), 4'(i % 10), 5'(i + 8), 5'd0, 5'd0);
         cyc();
      end
      idle();
      cyc(); cyc();

      // flush with count=3 and a concurrent enqueue
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_op(32'(300 + i), 32'(400 + i), 4'd7, 5'(i + 1), 5'd0, 5'd0);
         cyc();
      end
      stall = 1'b0; flush = 1'b1;
      set_op(32'd999, 32'd999, 4'd1, 5'd9, 5'd0, 5'd0);
      @(negedge clk);
      chk("flush_pre_count", 32'(count), 32'd3);
      chk("flush_lanes_forced", 32'(lane0_valid), 32'd0);
      cyc();
      flush = 1'b0; idle();
      @(negedge clk);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_l0_valid", 32'(lane0_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);

      // reset mid-stream
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_op(32'(500 + i), 32'(600 + i), 4'd8, 5'(i + 1), 5'd0, 5'd0);
         cyc();
      end
      stall = 1'b0; rst = 1'b1;
      set_op(32'd777, 32'd777, 4'd2, 5'd3, 5'd0, 5'd0);
      cyc();
      rst = 1'b0; idle();
      @(negedge clk);
      chk("rst2_count", 32'(count), 32'd0);
      chk("rst2_l0_valid", 32'(lane0_valid), 32'd0);
      chk("rst2_l0_a", lane0_SrcA, 32'd0);
      chk("rst2_l1_valid", 32'(lane1_valid), 32'd0);

      // illegal code 1100
      set_op(32'd70, 32'd80, 4'b1100, 5'd4, 5'd0, 5'd0);
      cyc();
      idle();
      @(negedge clk);
      if (TRAP) begin
         chk("trap_illegal", 32'(illegal_op), 32'd1);
         chk("trap_count", 32'(count), 32'd0);
      end else begin
         chk("noTrap_l0_valid", 32'(lane0_valid), 32'd1);
         chk("noTrap_l0_c", 32'(lane0_ALUControl), 32'd12);
      end
      cyc();
      @(negedge clk);
      chk("trap_pulse_end", 32'(illegal_op), 32'd0);
      chk("final_count", 32'(count), 32'd0);
      cyc(); cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
